// File: rtl/multicycle_control.sv
// Multicycle main controller. A Moore FSM that sequences each instruction through
// fetch / decode / execute / memory / writeback over a shared instruction+data memory
// port, waiting on a mem_ready handshake with an optional per-access timeout.
// Field encodings (regdst, alusrc, memtoreg, branch, jump, mode, aluop) match the
// single-cycle main decoder.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   mem_rdata           memory read data; instruction word during FETCH
//   mem_ready           current memory access completes this cycle
//   zero                ALU zero flag; the datapath gates pc_write_cond with it
//   mem_read/mem_write  memory request strobes
//   iord                memory address select (0 PC, 1 ALUOut)
//   ir_write, pc_write  instruction register load, unconditional PC load
//   pc_write_cond       PC load qualified by the branch condition in the datapath
//   reg_write           register file write enable
//   regdst              00 rt, 01 rd, 10 $31
//   memtoreg            00 ALU, 01 memory, 10 PC+4
//   alusrc              00 register, 01 sign-extended imm, 10 zero-extended imm
//   branch              00 none, 01 beq, 10 bne
//   jump                00 none, 01 j/jal, 10 jr
//   mode                0 W, 1 H, 2 HU, 3 B, 4 BU
//   aluop               0 add, 1 sub, 2 funct, 3 and, 4 lui, 5 slt, 6 xor, 7 or
//   instr_done          pulse on the last cycle of every instruction
//   illegal_op          pulse in DECODE for an unknown opcode
//   bus_error           pulse when a memory access times out
//   state_o             current state: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB,
//                       5 MEMWR, 6 EXEC, 7 ALUWB, 8 BRANCH, 9 JUMP

module multicycle_control #(
  parameter int unsigned ALUOP_W     = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned STATE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               reg_write,
  output logic [1:0]         regdst,
  output logic [1:0]         memtoreg,
  output logic [1:0]         alusrc,
  output logic [1:0]         branch,
  output logic [1:0]         jump,
  output logic [2:0]         mode,
  output logic [ALUOP_W-1:0] aluop,
  output logic               instr_done,
  output logic               illegal_op,
  output logic               bus_error,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLb    = 6'h20;
  localparam logic [5:0] OpLh    = 6'h21;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpLbu   = 6'h24;
  localparam logic [5:0] OpLhu   = 6'h25;
  localparam logic [5:0] OpSb    = 6'h28;
  localparam logic [5:0] OpSh    = 6'h29;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] FnJr    = 6'h08;

  localparam logic [2:0] AluAdd   = 3'd0;
  localparam logic [2:0] AluSub   = 3'd1;
  localparam logic [2:0] AluFunct = 3'd2;
  localparam logic [2:0] AluAnd   = 3'd3;
  localparam logic [2:0] AluLui   = 3'd4;
  localparam logic [2:0] AluSlt   = 3'd5;
  localparam logic [2:0] AluXor   = 3'd6;
  localparam logic [2:0] AluOr    = 3'd7;

  localparam logic [2:0] ModeW  = 3'd0;
  localparam logic [2:0] ModeH  = 3'd1;
  localparam logic [2:0] ModeHu = 3'd2;
  localparam logic [2:0] ModeB  = 3'd3;
  localparam logic [2:0] ModeBu = 3'd4;

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [5:0]        opcode_q, funct_q;

  logic              is_load, is_store, is_alu, is_branch, is_jump, is_legal;
  logic [2:0]        mode_c;
  logic [1:0]        exec_alusrc;
  logic [2:0]        exec_aluop;
  logic              mem_wait_state, timeout, ir_load;
  logic [2:0]        aluop_c;

  // zero is consumed by the datapath's branch gating; the middle instruction bits are
  // decoded by the datapath, only opcode and funct matter here.
  logic unused_inputs;
  assign unused_inputs = ^{zero, mem_rdata[25:6]};

  assign mem_wait_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  // mem_ready on the timeout cycle wins, so timeout is only raised without it.
  assign timeout = (MEM_TIMEOUT != 0) && mem_wait_state && !mem_ready &&
                   (wait_cnt_q == TimeoutVal);
  assign ir_load = (state_q == StFetch) && mem_ready;

  // Instruction class and per-opcode fields, from the latched opcode/funct only.
  always_comb begin
    is_load     = 1'b0;
    is_store    = 1'b0;
    is_alu      = 1'b0;
    is_branch   = 1'b0;
    is_jump     = 1'b0;
    mode_c      = ModeW;
    exec_alusrc = 2'b00;
    exec_aluop  = AluAdd;
    unique case (opcode_q)
      OpRtype: begin
        if (funct_q == FnJr) begin
          is_jump = 1'b1;
        end else begin
          is_alu     = 1'b1;
          exec_aluop = AluFunct;
        end
      end
      OpAddi:  begin is_alu = 1'b1; exec_alusrc = 2'b01; exec_aluop = AluAdd; end
      OpSlti:  begin is_alu = 1'b1; exec_alusrc = 2'b01; exec_aluop = AluSlt; end
      OpAndi:  begin is_alu = 1'b1; exec_alusrc = 2'b10; exec_aluop = AluAnd; end
      OpOri:   begin is_alu = 1'b1; exec_alusrc = 2'b10; exec_aluop = AluOr;  end
      OpXori:  begin is_alu = 1'b1; exec_alusrc = 2'b10; exec_aluop = AluXor; end
      OpLui:   begin is_alu = 1'b1; exec_alusrc = 2'b01; exec_aluop = AluLui; end
      OpLw:    begin is_load  = 1'b1; mode_c = ModeW;  end
      OpLh:    begin is_load  = 1'b1; mode_c = ModeH;  end
      OpLhu:   begin is_load  = 1'b1; mode_c = ModeHu; end
      OpLb:    begin is_load  = 1'b1; mode_c = ModeB;  end
      OpLbu:   begin is_load  = 1'b1; mode_c = ModeBu; end
      OpSw:    begin is_store = 1'b1; mode_c = ModeW;  end
      OpSh:    begin is_store = 1'b1; mode_c = ModeH;  end
      OpSb:    begin is_store = 1'b1; mode_c = ModeB;  end
      OpBeq, OpBne: is_branch = 1'b1;
      OpJ, OpJal:   is_jump   = 1'b1;
      default: ;
    endcase
  end

  assign is_legal = is_load | is_store | is_alu | is_branch | is_jump;

  // Next state and memory wait counter.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    unique case (state_q)
      StFetch: begin
        if (mem_ready)    state_d = StDecode;
        else if (timeout) state_d = StFetch;
      end
      StDecode: begin
        if (is_load || is_store) state_d = StMemAdr;
        else if (is_alu)         state_d = StExec;
        else if (is_branch)      state_d = StBranch;
        else if (is_jump)        state_d = StJump;
        else                     state_d = StFetch;
      end
      StMemAdr: state_d = is_load ? StMemRd : StMemWr;
      StMemRd: begin
        if (mem_ready)    state_d = StMemWb;
        else if (timeout) state_d = StFetch;
      end
      StMemWr: begin
        if (mem_ready || timeout) state_d = StFetch;
      end
      StExec:   state_d = StAluWb;
      StMemWb, StAluWb, StBranch, StJump: state_d = StFetch;
      default:  state_d = StFetch;
    endcase

    // Counter is zero outside wait states, so every wait state is entered with it
    // cleared; a finished or timed-out access (including FETCH restarting) clears it too.
    if (mem_wait_state && !mem_ready && !timeout) begin
      if (wait_cnt_q != {CntW{1'b1}}) wait_cnt_d = wait_cnt_q + 1'b1;
      else                            wait_cnt_d = wait_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StFetch;
      wait_cnt_q <= '0;
      opcode_q   <= '0;
      funct_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (ir_load) begin
        opcode_q <= mem_rdata[31:26];
        funct_q  <= mem_rdata[5:0];
      end
    end
  end

  // Outputs. reset overrides everything so write enables fall without waiting for a clock.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    regdst        = 2'b00;
    memtoreg      = 2'b00;
    alusrc        = 2'b00;
    branch        = 2'b00;
    jump          = 2'b00;
    mode          = 3'd0;
    aluop_c       = AluAdd;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    bus_error     = 1'b0;
    state_o       = STATE_W'(state_q);
    unique case (state_q)
      StFetch: begin
        mem_read   = 1'b1;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        bus_error  = timeout;
        instr_done = timeout;
      end
      StDecode: begin
        if (!is_legal) begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
        end
      end
      StMemAdr: alusrc = 2'b01;
      StMemRd: begin
        mem_read   = 1'b1;
        iord       = 1'b1;
        mode       = mode_c;
        bus_error  = timeout;
        instr_done = timeout;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        memtoreg   = 2'b01;
        instr_done = 1'b1;
      end
      StMemWr: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        mode       = mode_c;
        bus_error  = timeout;
        instr_done = mem_ready | timeout;
      end
      StExec: begin
        alusrc  = exec_alusrc;
        aluop_c = exec_aluop;
      end
      StAluWb: begin
        reg_write  = 1'b1;
        regdst     = (opcode_q == OpRtype) ? 2'b01 : 2'b00;
        instr_done = 1'b1;
      end
      StBranch: begin
        aluop_c       = AluSub;
        branch        = (opcode_q == OpBne) ? 2'b10 : 2'b01;
        pc_write_cond = 1'b1;
        instr_done    = 1'b1;
      end
      StJump: begin
        pc_write   = 1'b1;
        jump       = (opcode_q == OpRtype) ? 2'b10 : 2'b01;
        instr_done = 1'b1;
        if (opcode_q == OpJal) begin
          reg_write = 1'b1;
          regdst    = 2'b10;
          memtoreg  = 2'b10;
        end
      end
      default: ;
    endcase

    if (reset) begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      reg_write     = 1'b0;
      regdst        = 2'b00;
      memtoreg      = 2'b00;
      alusrc        = 2'b00;
      branch        = 2'b00;
      jump          = 2'b00;
      mode          = 3'd0;
      aluop_c       = AluAdd;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      bus_error     = 1'b0;
      state_o       = '0;
    end
  end

  assign aluop = ALUOP_W'(aluop_c);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: random instruction streams with random memory latencies,
// each instruction expanded into its expected per-cycle output trace from the
// instruction-class rules, then replayed against the DUT cycle by cycle.

module tb_multicycle_control;

  localparam int TO = 4;

  localparam logic [3:0] SFetch = 4'd0, SDecode = 4'd1, SMemAdr = 4'd2, SMemRd = 4'd3;
  localparam logic [3:0] SMemWb = 4'd4, SMemWr = 4'd5, SExec = 4'd6, SAluWb = 4'd7;
  localparam logic [3:0] SBranch = 4'd8, SJump = 4'd9;

  localparam int KLoad = 0, KStore = 1, KAlu = 2, KBranch = 3, KJump = 4, KIll = 5;

  localparam logic [5:0] OP_POOL [24] = '{
    6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
    6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h3F, 6'h01, 6'h09};
  localparam logic [5:0] FN_POOL [8] = '{
    6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h08, 6'h08};

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_rdata;
  logic        mem_ready, zero;
  logic        mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, reg_write;
  logic [1:0]  regdst, memtoreg, alusrc, branch, jump;
  logic [2:0]  mode;
  logic [3:0]  aluop;
  logic        instr_done, illegal_op, bus_error;
  logic [3:0]  state_o;

  always #5 clk = ~clk;

  multicycle_control #(
    .ALUOP_W    (4),
    .MEM_TIMEOUT(TO),
    .STATE_W    (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .zero         (zero),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .iord         (iord),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .reg_write    (reg_write),
    .regdst       (regdst),
    .memtoreg     (memtoreg),
    .alusrc       (alusrc),
    .branch       (branch),
    .jump         (jump),
    .mode         (mode),
    .aluop        (aluop),
    .instr_done   (instr_done),
    .illegal_op   (illegal_op),
    .bus_error    (bus_error),
    .state_o      (state_o)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, reg_write;
    logic [1:0] regdst, memtoreg, alusrc, branch, jump;
    logic [2:0] mode;
    logic [3:0] aluop;
    logic       instr_done, illegal_op, bus_error;
  } outv_t;

  typedef struct {
    logic        rdy;
    logic [31:0] rdata;
    outv_t       exp;
  } cyc_t;

  cyc_t  sched[$];
  int    checks = 0;
  int    errors = 0;
  outv_t obs;

  always_comb begin
    obs = '0;
    obs.st = state_o;
    obs.mem_read = mem_read;
    obs.mem_write = mem_write;
    obs.iord = iord;
    obs.ir_write = ir_write;
    obs.pc_write = pc_write;
    obs.pc_write_cond = pc_write_cond;
    obs.reg_write = reg_write;
    obs.regdst = regdst;
    obs.memtoreg = memtoreg;
    obs.alusrc = alusrc;
    obs.branch = branch;
    obs.jump = jump;
    obs.mode = mode;
    obs.aluop = aluop;
    obs.instr_done = instr_done;
    obs.illegal_op = illegal_op;
    obs.bus_error = bus_error;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return (fn == 6'h08) ? KJump : KAlu;
    if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) return KLoad;
    if (op inside {6'h28, 6'h29, 6'h2B}) return KStore;
    if (op inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F}) return KAlu;
    if (op inside {6'h04, 6'h05}) return KBranch;
    if (op inside {6'h02, 6'h03}) return KJump;
    return KIll;
  endfunction

  function automatic logic [2:0] mode_of(input logic [5:0] op);
    case (op)
      6'h21, 6'h29: return 3'd1;
      6'h25:        return 3'd2;
      6'h20, 6'h28: return 3'd3;
      6'h24:        return 3'd4;
      default:      return 3'd0;
    endcase
  endfunction

  // {alusrc, aluop} used in EXEC
  function automatic logic [4:0] exec_ctl(input logic [5:0] op);
    case (op)
      6'h00:   return {2'b00, 3'd2};
      6'h08:   return {2'b01, 3'd0};
      6'h0A:   return {2'b01, 3'd5};
      6'h0C:   return {2'b10, 3'd3};
      6'h0D:   return {2'b10, 3'd7};
      6'h0E:   return {2'b10, 3'd6};
      default: return {2'b01, 3'd4};
    endcase
  endfunction

  task automatic push(input outv_t v, input logic rdy, input logic [31:0] rdata);
    cyc_t c;
    c.rdy = rdy;
    c.rdata = rdata;
    c.exp = v;
    sched.push_back(c);
  endtask

  // A memory access lasting w not-ready cycles; ok=0 when it times out instead.
  task automatic add_access(input logic [3:0] st, input logic wr, input logic [2:0] md,
                            input int w, input logic [31:0] instr, output bit ok);
    outv_t v;
    logic  rdy;
    int    n;
    n = (w <= TO) ? w : TO;
    for (int k = 0; k <= n; k++) begin
      v = '0;
      v.st = st;
      v.iord = (st != SFetch);
      v.mem_read = !wr;
      v.mem_write = wr;
      v.mode = (st == SFetch) ? 3'd0 : md;
      rdy = (k == w);
      if (rdy) begin
        if (st == SFetch) begin
          v.ir_write = 1'b1;
          v.pc_write = 1'b1;
        end
        if (wr) v.instr_done = 1'b1;
      end else if (k == TO) begin
        v.bus_error = 1'b1;
        v.instr_done = 1'b1;
      end
      push(v, rdy, (rdy && st == SFetch) ? instr : $urandom);
    end
    ok = (w <= TO);
  endtask

  task automatic build(input logic [31:0] instr, input int wf, input int wm);
    outv_t      v;
    bit         ok;
    logic [5:0] op, fn;
    logic [4:0] ctl;
    int         k;
    op = instr[31:26];
    fn = instr[5:0];
    k = kind_of(op, fn);
    add_access(SFetch, 1'b0, 3'd0, wf, instr, ok);
    if (!ok) return;
    v = '0;
    v.st = SDecode;
    if (k == KIll) begin
      v.illegal_op = 1'b1;
      v.instr_done = 1'b1;
    end
    push(v, 1'($urandom), $urandom);
    if (k == KIll) return;
    v = '0;
    case (k)
      KLoad, KStore: begin
        v.st = SMemAdr;
        v.alusrc = 2'b01;
        push(v, 1'($urandom), $urandom);
        add_access((k == KLoad) ? SMemRd : SMemWr, k == KStore, mode_of(op), wm, instr, ok);
        if (ok && k == KLoad) begin
          v = '0;
          v.st = SMemWb;
          v.reg_write = 1'b1;
          v.memtoreg = 2'b01;
          v.instr_done = 1'b1;
          push(v, 1'($urandom), $urandom);
        end
      end
      KAlu: begin
        ctl = exec_ctl(op);
        v.st = SExec;
        v.alusrc = ctl[4:3];
        v.aluop = {1'b0, ctl[2:0]};
        push(v, 1'($urandom), $urandom);
        v = '0;
        v.st = SAluWb;
        v.reg_write = 1'b1;
        v.regdst = (op == 6'h00) ? 2'b01 : 2'b00;
        v.instr_done = 1'b1;
        push(v, 1'($urandom), $urandom);
      end
      KBranch: begin
        v.st = SBranch;
        v.aluop = 4'd1;
        v.branch = (op == 6'h05) ? 2'b10 : 2'b01;
        v.pc_write_cond = 1'b1;
        v.instr_done = 1'b1;
        push(v, 1'($urandom), $urandom);
      end
      default: begin
        v.st = SJump;
        v.pc_write = 1'b1;
        v.jump = (op == 6'h00) ? 2'b10 : 2'b01;
        v.instr_done = 1'b1;
        if (op == 6'h03) begin
          v.reg_write = 1'b1;
          v.regdst = 2'b10;
          v.memtoreg = 2'b10;
        end
        push(v, 1'($urandom), $urandom);
      end
    endcase
  endtask

  // Called at posedge+1; leaves at posedge+1 after the last replayed cycle.
  task automatic run_sched(input int limit, input string tag);
    cyc_t c;
    int   n;
    n = 0;
    while (sched.size() > 0 && n < limit) begin
      c = sched.pop_front();
      mem_ready = c.rdy;
      mem_rdata = c.rdata;
      zero = 1'($urandom);
      @(negedge clk);
      check($sformatf("%s cyc%0d", tag, n), 32'(obs), 32'(c.exp));
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_instr(input string tag, input logic [31:0] instr, input int wf,
                          input int wm);
    build(instr, wf, wm);
    run_sched(100, tag);
  endtask

  function automatic int rand_wait();
    int r;
    r = $urandom_range(0, 9);
    return (r < 6) ? 0 : $urandom_range(1, 6);
  endfunction

  initial begin
    cyc_t        c;
    logic [31:0] w;
    logic [5:0]  op;

    reset = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h0022_1820;
    zero = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs_ready_high", 32'(obs), 32'd0);
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs_ready_low", 32'(obs), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    do_instr("add", 32'h0022_1820, 0, 0);
    do_instr("lw_wait3", 32'h8C22_0004, 0, 3);
    do_instr("fetch_timeout", 32'h0022_1820, 7, 0);
    do_instr("fetch_ready_on_timeout", 32'h3422_00FF, TO, 0);
    do_instr("bne", 32'h1422_0003, 0, 0);
    do_instr("beq", 32'h1022_0003, 1, 0);
    do_instr("jal", 32'h0C00_0010, 0, 0);
    do_instr("jr", 32'h03E0_0008, 0, 0);
    do_instr("illegal_3f", 32'hFC00_0000, 0, 0);
    do_instr("lw_timeout", 32'h8C22_0004, 0, 6);
    do_instr("sw_ready_on_timeout", 32'hAC22_0004, 2, TO);

    // Reset in the first MEMWR cycle of a store with pending wait cycles.
    build(32'hAC22_0004, 0, 3);
    run_sched(3, "sw_pre");
    c = sched.pop_front();
    mem_ready = c.rdy;
    mem_rdata = c.rdata;
    @(negedge clk);
    check("sw_memwr", 32'(obs), 32'(c.exp));
    #1;
    reset = 1'b1;
    #1;
    check("rst_memwr_outputs", 32'(obs), 32'd0);
    check("rst_memwr_mem_write", 32'(mem_write), 32'd0);
    check("rst_memwr_state", 32'(state_o), 32'd0);
    sched.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_instr("after_reset_sw", 32'hAC22_0004, 0, 1);

    for (int i = 0; i < 300; i++) begin
      w = $urandom;
      op = OP_POOL[$urandom_range(0, 23)];
      w[31:26] = op;
      if (op == 6'h00) w[5:0] = FN_POOL[$urandom_range(0, 7)];
      do_instr($sformatf("rand%0d op%02h", i, op), w, rand_wait(), rand_wait());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
